// File: rtl/package_parse.sv
// ---------------------------------------------------------------------------
// package_parse -- receive-side packet parser for the ADC capture path.
//
// Hunts for a header carrying SYNC_WORD in bits [31:16], forwards the N
// payload words that follow (with sop/eop markers) through a single output
// register, checks the trailing XOR checksum and reports per-packet status.
// Error counters saturate at all-ones.
//
// Optional feature (compile-time macro PKT_PARSE_SEQ_CHK_EN):
//   defined   -> track the expected sequence number; a discontinuity bumps
//                seq_err_cnt_o and forces pkt_ok_o low for that packet.
//   undefined -> no tracking logic, seq_err_cnt_o tied to 0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_data_i/in_vld_i      input word stream
//   in_rdy_o                parser accepts the word this cycle
//   out_data_o/out_vld_o    payload word out (registered)
//   out_sop_o/out_eop_o     first/last payload word markers
//   out_rdy_i               downstream accepts the output word
//   pkt_done_o              1-cycle pulse after the trailer is consumed
//   pkt_ok_o/pkt_seq_o      status/sequence of the finished packet
//   sync_drop_cnt_o         words dropped while hunting
//   len_err_cnt_o           sync headers with length 0
//   csum_err_cnt_o          trailer checksum mismatches
//   seq_err_cnt_o           sequence discontinuities
// ---------------------------------------------------------------------------
module package_parse #(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      in_data_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    output logic [31:0]      out_data_o,
    output logic             out_vld_o,
    output logic             out_sop_o,
    output logic             out_eop_o,
    input  logic             out_rdy_i,
    output logic             pkt_done_o,
    output logic             pkt_ok_o,
    output logic [7:0]       pkt_seq_o,
    output logic [CNT_W-1:0] sync_drop_cnt_o,
    output logic [CNT_W-1:0] len_err_cnt_o,
    output logic [CNT_W-1:0] csum_err_cnt_o,
    output logic [CNT_W-1:0] seq_err_cnt_o
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, TRAILER} state_t;

    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [31:0]      csum_q, csum_d;
    logic [7:0]       seq_q, seq_d;
    logic             first_q, first_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_vld_q, out_vld_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic             pkt_done_q, pkt_done_d;
    logic             pkt_ok_q, pkt_ok_d;
    logic [7:0]       pkt_seq_q, pkt_seq_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] len_cnt_q, len_cnt_d;
    logic [CNT_W-1:0] csum_cnt_q, csum_cnt_d;

    logic             accept;
    logic             hdr_ok;
    logic             seq_bad;   // current packet had a sequence discontinuity

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Only PAYLOAD can be stalled: it is the only state that loads the
    // output register, so HUNT/TRAILER keep consuming regardless.
    assign in_rdy_o = !rst_i && ((state_q != PAYLOAD) || !out_vld_q || out_rdy_i);
    assign accept   = in_vld_i && in_rdy_o;
    assign hdr_ok   = accept && (state_q == HUNT) &&
                      (in_data_i[31:16] == SYNC_WORD) && (in_data_i[7:0] != 8'd0);

`ifdef PKT_PARSE_SEQ_CHK_EN
    logic [7:0]       exp_seq_q;
    logic             seq_seen_q;   // no expectation until the first header
    logic             seq_bad_q;
    logic [CNT_W-1:0] seq_cnt_q;
    logic             seq_miss;

    assign seq_miss      = seq_seen_q && (in_data_i[15:8] != exp_seq_q);
    assign seq_bad       = seq_bad_q;
    assign seq_err_cnt_o = seq_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_seq_q  <= '0;
            seq_seen_q <= 1'b0;
            seq_bad_q  <= 1'b0;
            seq_cnt_q  <= '0;
        end else if (hdr_ok) begin
            // Resynchronise to whatever arrived, flagged or not.
            exp_seq_q  <= in_data_i[15:8] + 8'd1;
            seq_seen_q <= 1'b1;
            seq_bad_q  <= seq_miss;
            if (seq_miss) seq_cnt_q <= sat_inc(seq_cnt_q);
        end
    end
`else
    assign seq_bad       = 1'b0;
    assign seq_err_cnt_o = '0;
`endif

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        first_d    = first_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q && !out_rdy_i;
        out_sop_d  = out_sop_q;
        out_eop_d  = out_eop_q;
        pkt_done_d = 1'b0;
        pkt_ok_d   = pkt_ok_q;
        pkt_seq_d  = pkt_seq_q;
        drop_cnt_d = drop_cnt_q;
        len_cnt_d  = len_cnt_q;
        csum_cnt_d = csum_cnt_q;

        case (state_q)
            HUNT: begin
                if (accept) begin
                    if (in_data_i[31:16] != SYNC_WORD) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else if (in_data_i[7:0] == 8'd0) begin
                        len_cnt_d = sat_inc(len_cnt_q);
                    end else begin
                        seq_d   = in_data_i[15:8];
                        rem_d   = in_data_i[7:0];
                        csum_d  = in_data_i;
                        first_d = 1'b1;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    out_data_d = in_data_i;
                    out_vld_d  = 1'b1;
                    out_sop_d  = first_q;
                    out_eop_d  = (rem_q == 8'd1);
                    first_d    = 1'b0;
                    csum_d     = csum_q ^ in_data_i;
                    rem_d      = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = TRAILER;
                end
            end
            TRAILER: begin
                if (accept) begin
                    pkt_done_d = 1'b1;
                    pkt_ok_d   = (in_data_i == csum_q) && !seq_bad;
                    pkt_seq_d  = seq_q;
                    if (in_data_i != csum_q) csum_cnt_d = sat_inc(csum_cnt_q);
                    state_d    = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            rem_q      <= '0;
            csum_q     <= '0;
            seq_q      <= '0;
            first_q    <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            pkt_ok_q   <= 1'b0;
            pkt_seq_q  <= '0;
            drop_cnt_q <= '0;
            len_cnt_q  <= '0;
            csum_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            first_q    <= first_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            pkt_done_q <= pkt_done_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_seq_q  <= pkt_seq_d;
            drop_cnt_q <= drop_cnt_d;
            len_cnt_q  <= len_cnt_d;
            csum_cnt_q <= csum_cnt_d;
        end
    end

    assign out_data_o      = out_data_q;
    assign out_vld_o       = out_vld_q;
    assign out_sop_o       = out_sop_q;
    assign out_eop_o       = out_eop_q;
    assign pkt_done_o      = pkt_done_q;
    assign pkt_ok_o        = pkt_ok_q;
    assign pkt_seq_o       = pkt_seq_q;
    assign sync_drop_cnt_o = drop_cnt_q;
    assign len_err_cnt_o   = len_cnt_q;
    assign csum_err_cnt_o  = csum_cnt_q;

endmodule

// File: tb/tb_package_parse.sv
// ---------------------------------------------------------------------------
// tb_package_parse -- scoreboard bench for package_parse. Stimulus pushes
// expected payload words and packet status into queues; a monitor pops and
// compares whenever the DUT transfers a word or pulses pkt_done.
// ---------------------------------------------------------------------------
module tb_package_parse;
    localparam int CNT_W = 16;
    localparam logic [15:0] SYNC = 16'hA5C3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      in_data = '0;
    logic             in_vld = 1'b0;
    logic             in_rdy;
    logic [31:0]      out_data;
    logic             out_vld, out_sop, out_eop;
    logic             out_rdy = 1'b1;
    logic             pkt_done, pkt_ok;
    logic [7:0]       pkt_seq;
    logic [CNT_W-1:0] drop_cnt, len_cnt, csum_cnt, seq_cnt;

    always #5 clk = ~clk;

    package_parse #(.SYNC_WORD(SYNC), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_vld_i(in_vld), .in_rdy_o(in_rdy),
        .out_data_o(out_data), .out_vld_o(out_vld), .out_sop_o(out_sop),
        .out_eop_o(out_eop), .out_rdy_i(out_rdy),
        .pkt_done_o(pkt_done), .pkt_ok_o(pkt_ok), .pkt_seq_o(pkt_seq),
        .sync_drop_cnt_o(drop_cnt), .len_err_cnt_o(len_cnt),
        .csum_err_cnt_o(csum_cnt), .seq_err_cnt_o(seq_cnt)
    );

    typedef struct packed { logic [31:0] d; logic sop; logic eop; } pl_t;
    typedef struct packed { logic ok; logic [7:0] seq; } pk_t;

    pl_t pl_q[$];
    pk_t pk_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  bp_en = 1'b0;
    logic [31:0] pay [16];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Backpressure pattern 1010... on out_rdy.
    always @(negedge clk) if (bp_en) out_rdy = ~out_rdy;

    // Monitor: samples mid-low-phase, when inputs and outputs are settled.
    logic        stall_p = 1'b0;
    logic [33:0] stall_v = '0;
    pl_t         e_pl;
    pk_t         e_pk;
    always begin
        @(negedge clk); #3;
        if (!rst && stall_p) begin
            chk("stall_vld", {31'd0, out_vld}, 32'd1);
            chk("stall_data", out_data, stall_v[33:2]);
            chk("stall_flags", {30'd0, out_sop, out_eop}, {30'd0, stall_v[1:0]});
        end
        if (out_vld && out_rdy) begin
            if (pl_q.size() == 0) chk("unexpected_word", out_data, 32'hxxxx_xxxx);
            else begin
                e_pl = pl_q.pop_front();
                chk("pl_data", out_data, e_pl.d);
                chk("pl_sop_eop", {30'd0, out_sop, out_eop}, {30'd0, e_pl.sop, e_pl.eop});
            end
        end
        if (pkt_done) begin
            if (pk_q.size() == 0) chk("spurious_done", {24'd0, pkt_seq}, 32'hxxxx_xxxx);
            else begin
                e_pk = pk_q.pop_front();
                chk("pkt_ok", {31'd0, pkt_ok}, {31'd0, e_pk.ok});
                chk("pkt_seq", {24'd0, pkt_seq}, {24'd0, e_pk.seq});
            end
        end
        stall_p = !rst && out_vld && !out_rdy;
        stall_v = {out_data, out_sop, out_eop};
    end

    // All tasks start and end at a falling edge.
    task automatic send(input logic [31:0] w);
        int t = 0;
        in_data = w;
        in_vld  = 1'b1;
        #1;
        while (!in_rdy && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!in_rdy) chk("in_rdy_timeout", {31'd0, in_rdy}, 32'd1);
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] seq, input int n,
                            input logic [31:0] flip, input logic exp_ok);
        logic [31:0] cs;
        cs = {SYNC, seq, n[7:0]};
        send(cs);
        for (int i = 0; i < n; i++) begin
            pl_q.push_back('{d: pay[i], sop: (i == 0), eop: (i == n - 1)});
            cs = cs ^ pay[i];
            send(pay[i]);
        end
        pk_q.push_back('{ok: exp_ok, seq: seq});
        send(cs ^ flip);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_vld = 1'b0; bp_en = 1'b0; out_rdy = 1'b1;
        #1 chk("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        @(negedge clk); #1;
        chk("rst_out_flags", {27'd0, out_vld, out_sop, out_eop, pkt_done, pkt_ok}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_pkt_seq", {24'd0, pkt_seq}, 32'd0);
        chk("rst_cnts", {drop_cnt, len_cnt} | {csum_cnt, seq_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((pl_q.size() + pk_q.size()) != 0 && t < 300) begin
            @(negedge clk); t++;
        end
        chk("drain", pl_q.size() + pk_q.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_cnts(input string tag, input int d, input int l,
                            input int c, input int s);
        chk({tag, "_drop"}, {16'd0, drop_cnt}, d);
        chk({tag, "_len"},  {16'd0, len_cnt},  l);
        chk({tag, "_csum"}, {16'd0, csum_cnt}, c);
        chk({tag, "_seq"},  {16'd0, seq_cnt},  s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Single good packet, trailer 0xA5C30503.
        do_reset();
        pay[0] = 32'h11111111; pay[1] = 32'h22222222; pay[2] = 32'h33333333;
        send_pkt(8'h05, 3, 32'h0, 1'b1);
        wait_idle();
        chk_cnts("t1", 0, 0, 0, 0);

        // 2. Same packet, trailer bit 0 flipped.
        do_reset();
        send_pkt(8'h05, 3, 32'h1, 1'b0);
        wait_idle();
        chk_cnts("t2", 0, 0, 1, 0);

        // 3. Junk, zero-length header, then a 1-word packet.
        do_reset();
        repeat (4) send(32'hDEADBEEF);
        send(32'hA5C3_0900);
        pay[0] = 32'hCAFEF00D;
        send_pkt(8'h0A, 1, 32'h0, 1'b1);
        wait_idle();
        chk_cnts("t3", 4, 1, 0, 0);

        // 4. N=8 with out_rdy toggling.
        do_reset();
        for (int i = 0; i < 8; i++) pay[i] = 32'h8000_0000 + 32'(i * 3);
        bp_en = 1'b1;
        send_pkt(8'h20, 8, 32'h0, 1'b1);
        wait_idle();
        bp_en = 1'b0; out_rdy = 1'b1;
        chk_cnts("t4", 0, 0, 0, 0);

        // 5. Back-to-back packets with seq 1, 2, 4, 5.
        do_reset();
        pay[0] = 32'h12345678;
        send_pkt(8'h01, 1, 32'h0, 1'b1);
        send_pkt(8'h02, 1, 32'h0, 1'b1);
`ifdef PKT_PARSE_SEQ_CHK_EN
        send_pkt(8'h04, 1, 32'h0, 1'b0);
`else
        send_pkt(8'h04, 1, 32'h0, 1'b1);
`endif
        send_pkt(8'h05, 1, 32'h0, 1'b1);
        wait_idle();
`ifdef PKT_PARSE_SEQ_CHK_EN
        chk_cnts("t5", 0, 0, 0, 1);
`else
        chk_cnts("t5", 0, 0, 0, 0);
`endif

        // 6. Reset after 2 of 5 payload words, then a fresh packet.
        do_reset();
        pay[0] = 32'hAAAA0001; pay[1] = 32'hAAAA0002;
        send({SYNC, 8'h07, 8'd5});
        pl_q.push_back('{d: pay[0], sop: 1'b1, eop: 1'b0});
        send(pay[0]);
        pl_q.push_back('{d: pay[1], sop: 1'b0, eop: 1'b0});
        send(pay[1]);
        do_reset();
        chk("t6_partial_drained", pl_q.size(), 32'd0);
        pay[0] = 32'h0BADF00D; pay[1] = 32'h76543210;
        send_pkt(8'h08, 2, 32'h0, 1'b1);
        wait_idle();
        chk_cnts("t6", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/package_parse.md
# package_parse

Receive-side packet parser for the ADC capture path: consumes the 32-bit word stream produced by the packet generator, hunts for header sync, and strips header and trailer. It forwards payload words downstream with start/end markers, verifies the XOR checksum, and reports per-packet status plus saturating error counters. It sits at the far end of the capture link, on the host/loopback side, and mirrors the transmit-side packetizer.

## Interface
- SYNC_WORD, 16'hA5C3: expected header bits [31:16].
- CNT_W, 16: width of each error counter.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  incoming word.
- in_vld  in  1  in_data valid.
- in_rdy  out  1  parser accepts word; transfer when in_vld && in_rdy.
- out_data  out  32  payload word.
- out_vld  out  1  out_data valid.
- out_sop  out  1  first payload word of packet.
- out_eop  out  1  last payload word of packet.
- out_rdy  in  1  downstream accepts word.
- pkt_done  out  1  one-cycle pulse after trailer is consumed.
- pkt_ok  out  1  valid with pkt_done: checksum matched (and sequence ok when checking is compiled in).
- pkt_seq  out  8  sequence number of the finished packet, valid with pkt_done.
- sync_drop_cnt  out  CNT_W  words discarded while hunting.
- len_err_cnt  out  CNT_W  headers with length 0.
- csum_err_cnt  out  CNT_W  trailer mismatches.
- seq_err_cnt  out  CNT_W  sequence discontinuities (0 when feature is off).

## Operation
- Packet format:
  - Header: [31:16]=SYNC_WORD, [15:8]=seq, [7:0]=len N (1..255 payload words).
  - Then N payload words.
  - Then one trailer word = XOR of header and all N payload words.
- FSM states HUNT, PAYLOAD, TRAILER. Reset state is HUNT.
- HUNT, on each accepted word:
  - sync mismatch: drop the word, sync_drop_cnt+1.
  - sync match with len=0: len_err_cnt+1, stay in HUNT.
  - otherwise: latch seq, load rem=N, csum=word, go to PAYLOAD.
- PAYLOAD, on each accepted word:
  - Present the word on out_data; csum^=word; rem-1.
  - out_sop on the first word; out_eop when rem==1.
  - Go to TRAILER after the eop word.
- TRAILER, on the accepted word:
  - pkt_ok=(word==csum).
  - Mismatch: csum_err_cnt+1.
  - Pulse pkt_done, return to HUNT.
  - Payload already forwarded is not retracted; downstream uses pkt_ok.
- Backpressure: in_rdy = !out_vld || out_rdy in PAYLOAD; in_rdy=1 in HUNT and TRAILER. The single output register never overflows.
- Counters saturate at all-ones and never wrap.
- Sync inside a payload is treated as data. No resync until the trailer is consumed.
- A header arriving the cycle after the trailer is accepted normally (back-to-back packets, zero idle).

## Timing
- Payload latency: one cycle from input acceptance to out_vld (registered output).
- pkt_done: asserted the cycle after trailer acceptance, for exactly one cycle.
- Counters update the cycle after the causing word is accepted.
- out_data, out_sop and out_eop stay stable while out_vld && !out_rdy.
- Reset mid-packet returns to HUNT the next cycle and discards any partial packet.
- Reset values: in_rdy=0 during rst; out_vld, out_sop, out_eop, pkt_done and pkt_ok = 0; out_data=0, pkt_seq=0; all counters 0; FSM=HUNT.

## Configuration
- PKT_PARSE_SEQ_CHK_EN defined:
  - The parser tracks expected seq (last+1, mod 256).
  - A mismatch on a valid header increments seq_err_cnt and forces pkt_ok=0 for that packet.
  - The expected value then resynchronises to the received seq+1.
  - The first packet after reset is never flagged.
- Undefined: no tracking logic; seq_err_cnt is tied to 0; pkt_ok depends on the checksum only.

## Test plan
- Stream: one packet, seq=0x05, N=3, payload 0x11111111/0x22222222/0x33333333, correct trailer. Required: three out words, sop on the first, eop on the third; pkt_done with pkt_ok=1 and pkt_seq=0x05; all counters 0.
- Corrupted trailer: same packet with trailer bit 0 flipped. Required: payload still forwarded; pkt_ok=0; csum_err_cnt=1.
- Junk then packet: 4 junk words 0xDEADBEEF, then a packet with len=0, then a valid N=1 packet. Required: sync_drop_cnt=4, len_err_cnt=1, one good packet out.
- Backpressure: out_rdy toggled 1010… during an N=8 packet. Required: all 8 words delivered in order with no loss or duplication; out_data stable while stalled.
- Sequence check (macro on): packets with seq 1, 2, 4, 5. Required: seq_err_cnt=1, pkt_ok=0 only for seq 4. With the macro off: seq_err_cnt=0 and all pkt_ok=1.
- Reset mid-packet: rst asserted after 2 of 5 payload words, then a new valid packet. Required: no pkt_done for the aborted packet; the new packet parses with pkt_ok=1.
